// File: rtl/bcd_digit_adder_reg.sv
// Single-digit BCD adder (A + B + cin) with a registered 8-bit result word.
// Optional macro BCD_INVALID_FLAG_EN drives out[5] with a non-BCD operand flag.
module bcd_digit_adder_reg (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [7:0] prev,
    output logic [7:0] out
);

    // Operand bits are interleaved: even nibble bits carry A, odd carry B.
    function automatic logic [3:0] decode_a(input logic [3:0] lo, input logic [3:0] hi);
        decode_a = {hi[2], hi[0], lo[2], lo[0]};
    endfunction

    function automatic logic [3:0] decode_b(input logic [3:0] lo, input logic [3:0] hi);
        decode_b = {hi[3], hi[1], lo[3], lo[1]};
    endfunction

    // Decimal correction: any binary sum above 9 gets +6 and a decimal carry.
    function automatic logic [4:0] bcd_correct(input logic [4:0] t);
        logic [4:0] adj;
        adj = t + 5'd6;
        if (t > 5'd9) begin
            bcd_correct = {1'b1, adj[3:0]};
        end else begin
            bcd_correct = {1'b0, t[3:0]};
        end
    endfunction

    logic [3:0] w_a_s;
    logic [3:0] w_b_s;
    logic [4:0] w_t_s;
    logic [4:0] w_res_s;
    logic       w_flag_s;
    logic [7:0] w_next_s;
    logic [7:0] r_out_r;

    // Operand decode, binary sum and correction.
    always_comb begin
        w_a_s   = decode_a(in1, in2);
        w_b_s   = decode_b(in1, in2);
        w_t_s   = {1'b0, w_a_s} + {1'b0, w_b_s} + {4'b0000, in3[0]};
        w_res_s = bcd_correct(w_t_s);
    end

`ifdef BCD_INVALID_FLAG_EN
    // Flag operands outside the decimal range.
    always_comb begin
        if ((w_a_s > 4'd9) || (w_b_s > 4'd9)) begin
            w_flag_s = 1'b1;
        end else begin
            w_flag_s = 1'b0;
        end
    end
`else
    // Without the flag, out[5] is a plain feedback of prev[5].
    always_comb begin
        w_flag_s = prev[5];
    end
`endif

    // Pack sum digit into even bits, carry into bit 7, feedback into odd bits.
    always_comb begin
        w_next_s = {w_res_s[4], w_res_s[3], w_flag_s, w_res_s[2],
                    prev[3],    w_res_s[1], prev[1],  w_res_s[0]};
    end

    // Result register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_r <= 8'h00;
        end else begin
            r_out_r <= w_next_s;
        end
    end

    assign out = r_out_r;

endmodule

// File: tb/tb_bcd_digit_adder_reg.sv
// Scoreboard bench for bcd_digit_adder_reg: directed vectors, async reset, random stimulus.
module tb_bcd_digit_adder_reg;

    logic       clock;
    logic       reset_n;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] in3;
    logic [7:0] prev;
    logic [7:0] out;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    bcd_digit_adder_reg dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .prev    (prev),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: decimal arithmetic on integers, then place bits by name.
    function automatic logic [7:0] model(input logic [3:0] i1, input logic [3:0] i2,
                                         input logic [3:0] i3, input logic [7:0] pv);
        int a, b, t, digit, carry, inval;
        logic [7:0] o;
        logic [3:0] d;
        a = 8 * i2[2] + 4 * i2[0] + 2 * i1[2] + i1[0];
        b = 8 * i2[3] + 4 * i2[1] + 2 * i1[3] + i1[1];
        t = a + b + i3[0];
        carry = (t > 9) ? 1 : 0;
        digit = carry ? (t + 6) % 16 : t;
        d = digit[3:0];
        inval = (a > 9 || b > 9) ? 1 : 0;
        o = 8'h00;
        o[7] = carry[0];
        o[6] = d[3];
        o[4] = d[2];
        o[2] = d[1];
        o[0] = d[0];
`ifdef BCD_INVALID_FLAG_EN
        o[5] = inval[0];
`else
        o[5] = pv[5];
`endif
        o[3] = pv[3];
        o[1] = pv[1];
        return o;
    endfunction

    task automatic drive(input logic [3:0] i1, input logic [3:0] i2,
                         input logic [3:0] i3, input logic [7:0] pv);
        @(negedge clock);
        reset_n = 1'b1;
        in1 = i1; in2 = i2; in3 = i3; prev = pv;
        exp_q.push_back(model(i1, i2, i3, pv));
    endtask

    // Assert reset mid-cycle, check immediate clear, hold for n cycles.
    task automatic pulse_reset(input int n);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clear", out, 8'h00);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            in1 = 4'($urandom); in2 = 4'($urandom);
            in3 = 4'($urandom); prev = 8'($urandom);
            exp_q.push_back(8'h00);
        end
    endtask

    // Monitor: the DUT produces a word every cycle; compare just after the edge.
    always @(posedge clock) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", out, e);
        end
    end

    initial begin
        reset_n = 1'b1;
        in1 = 4'h0; in2 = 4'h0; in3 = 4'h0; prev = 8'h00;
        #2;
        reset_n = 1'b0;
        in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; prev = 8'hFF;
        #1;
        check("reset", out, 8'h00);
        @(negedge clock);
        exp_q.push_back(8'h00);

        drive(4'b0011, 4'b0000, 4'b0000, 8'h00);
        drive(4'b0111, 4'b0011, 4'b0000, 8'h00);
        drive(4'b0011, 4'b0011, 4'b0000, 8'h00);
        drive(4'b1111, 4'b0011, 4'b0001, 8'h00);
        drive(4'b0011, 4'b1100, 4'b0001, 8'h00);
        drive(4'b0000, 4'b0000, 4'b0000, 8'b10110011);
        drive(4'b0011, 4'b0101, 4'b0000, 8'b10110011);
        drive(4'b1111, 4'b1111, 4'b1111, 8'hFF);
        drive(4'b0000, 4'b0000, 4'b1110, 8'h55);

        pulse_reset(2);
        drive(4'b0111, 4'b0011, 4'b0001, 8'hAA);

        for (int i = 0; i < 200; i++) begin
            drive(4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
            if (i == 97) pulse_reset(1);
        end

        @(negedge clock);
        @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
